// File: rtl/peek_arbiter_pkg.sv
// Shared definitions for the display-peek / CPU read arbiter.
package peek_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RD  = 2'd1,
        DISP_RD = 2'd2
    } arb_state_e;

    // Data returned to a requester whose read was abandoned by the memory timeout.
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    localparam int DEF_STARVE_LIMIT = 8;
    localparam int DEF_MEM_TIMEOUT  = 15;

    // True while a memory read is outstanding.
    function automatic logic is_read_state(input arb_state_e st);
        return (st == CPU_RD) || (st == DISP_RD);
    endfunction

endpackage

// File: rtl/peek_arbiter_if.sv
// Requester and memory-side signals of the peek arbiter.
interface peek_arbiter_if;

    logic        cpuReq;
    logic [31:0] cpuAddr;
    logic [31:0] cpuData;
    logic        cpuValid;

    logic        dispReq;
    logic [31:0] dispAddr;
    logic [31:0] dispData;
    logic        dispValid;

    logic        memRe;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic        memReady;

    logic        timeoutErr;

    // Environment side: requesters and memory.
    modport master (
        output cpuReq, cpuAddr, dispReq, dispAddr, memData, memReady,
        input  cpuData, cpuValid, dispData, dispValid, memRe, memAddr, timeoutErr
    );

    // Arbiter side.
    modport slave (
        input  cpuReq, cpuAddr, dispReq, dispAddr, memData, memReady,
        output cpuData, cpuValid, dispData, dispValid, memRe, memAddr, timeoutErr
    );

endinterface

// File: rtl/peek_arbiter_starve_counter.sv
// Counts consecutive CPU grants taken while the display waits; saturates at LIMIT.
module starve_counter #(
    parameter int LIMIT = 8
) (
    input  logic Clk,
    input  logic Rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_r;

    // Counter register: clear has priority, increment stops at the limit.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != CNT_W'(LIMIT))) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_limit = (cnt_r == CNT_W'(LIMIT));

endmodule

// File: rtl/peek_arbiter.sv
// Arbitrates CPU reads and display peeks onto a single memory read port,
// with anti-starvation for the display and a per-read memory timeout.
module peek_arbiter
    import peek_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT
) (
    input  logic          Clk,
    input  logic          Rst,
    peek_arbiter_if.slave bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    arb_state_e        state_r;
    arb_state_e        state_s;
    logic              grant_cpu_s;
    logic              grant_disp_s;
    logic              rd_done_s;
    logic              rd_timeout_s;
    logic              rd_end_s;
    logic [31:0]       rd_data_s;
    logic              at_limit_s;
    logic              starve_inc_s;
    logic              starve_clr_s;
    logic [WAIT_W-1:0] wait_cnt_r;

    logic              memRe_r;
    logic [31:0]       memAddr_r;
    logic [31:0]       cpuData_r;
    logic [31:0]       dispData_r;
    logic              cpuValid_r;
    logic              dispValid_r;
    logic              timeoutErr_r;

    // Next-state logic: grant decisions only from IDLE, so a completion is always followed by an IDLE cycle.
    always_comb begin
        state_s      = state_r;
        grant_cpu_s  = 1'b0;
        grant_disp_s = 1'b0;
        rd_done_s    = 1'b0;
        rd_timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.dispReq && at_limit_s) begin
                    state_s      = DISP_RD;
                    grant_disp_s = 1'b1;
                end else if (bus.cpuReq) begin
                    state_s     = CPU_RD;
                    grant_cpu_s = 1'b1;
                end else if (bus.dispReq) begin
                    state_s      = DISP_RD;
                    grant_disp_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            CPU_RD, DISP_RD: begin
                if (bus.memReady) begin
                    rd_done_s = 1'b1;
                    state_s   = IDLE;
                end else if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    rd_timeout_s = 1'b1;
                    state_s      = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign rd_end_s     = rd_done_s || rd_timeout_s;
    assign rd_data_s    = rd_timeout_s ? TIMEOUT_DATA : bus.memData;
    assign starve_inc_s = grant_cpu_s && bus.dispReq;
    assign starve_clr_s = grant_disp_s || ((state_r == IDLE) && !bus.dispReq);

    // State register; reset abandons any in-flight read.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Wait counter: cycles spent in a read state without memReady.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wait_cnt_r <= '0;
        end else if (is_read_state(state_r) && !rd_end_s) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= '0;
        end
    end

    // Memory port: address captured from the winner on grant, enable held until completion or timeout.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            memRe_r   <= 1'b0;
            memAddr_r <= 32'h0000_0000;
        end else if (grant_cpu_s) begin
            memRe_r   <= 1'b1;
            memAddr_r <= bus.cpuAddr;
        end else if (grant_disp_s) begin
            memRe_r   <= 1'b1;
            memAddr_r <= bus.dispAddr;
        end else if (rd_end_s) begin
            memRe_r   <= 1'b0;
            memAddr_r <= memAddr_r;
        end else begin
            memRe_r   <= memRe_r;
            memAddr_r <= memAddr_r;
        end
    end

    // Result delivery: data registers hold between reads, valids pulse for one cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cpuData_r   <= 32'h0000_0000;
            dispData_r  <= 32'h0000_0000;
            cpuValid_r  <= 1'b0;
            dispValid_r <= 1'b0;
        end else if (rd_end_s && (state_r == CPU_RD)) begin
            cpuData_r   <= rd_data_s;
            cpuValid_r  <= 1'b1;
            dispValid_r <= 1'b0;
        end else if (rd_end_s && (state_r == DISP_RD)) begin
            dispData_r  <= rd_data_s;
            dispValid_r <= 1'b1;
            cpuValid_r  <= 1'b0;
        end else begin
            cpuValid_r  <= 1'b0;
            dispValid_r <= 1'b0;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            timeoutErr_r <= 1'b0;
        end else if (rd_timeout_s) begin
            timeoutErr_r <= 1'b1;
        end else begin
            timeoutErr_r <= timeoutErr_r;
        end
    end

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .Clk      (Clk),
        .Rst      (Rst),
        .inc      (starve_inc_s),
        .clr      (starve_clr_s),
        .at_limit (at_limit_s)
    );

    assign bus.memRe      = memRe_r;
    assign bus.memAddr    = memAddr_r;
    assign bus.cpuData    = cpuData_r;
    assign bus.dispData   = dispData_r;
    assign bus.cpuValid   = cpuValid_r;
    assign bus.dispValid  = dispValid_r;
    assign bus.timeoutErr = timeoutErr_r;

endmodule

// File: tb/tb_peek_arbiter.sv
// Directed scoreboard bench for peek_arbiter with a latency-programmable memory model.
module tb_peek_arbiter;

    typedef struct {
        bit          disp;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic Clk;
    logic Rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    int          mem_lat   = 2;
    bit          mem_en    = 1'b1;
    bit          mem_force = 1'b0;
    int          mem_cnt   = 0;
    logic [31:0] last_mem_addr = 32'h0;

    peek_arbiter_if mif ();

    peek_arbiter #(
        .STARVE_LIMIT (8),
        .MEM_TIMEOUT  (15)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (mif)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] mem_func(input logic [31:0] a);
        if (a == 32'h10) return 32'h3333_3333;
        return (a ^ 32'h5A5A_0000) + 32'h1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model: answers mem_lat cycles after memRe is first seen.
    initial begin
        mif.memReady = 1'b0;
        mif.memData  = 32'h0;
        forever begin
            @(negedge Clk);
            mif.memReady = 1'b0;
            if (mem_force) begin
                mif.memReady = 1'b1;
                mif.memData  = 32'hBAD0_BAD0;
            end else if (mem_en && mif.memRe) begin
                if (mem_cnt == mem_lat) begin
                    mif.memReady = 1'b1;
                    mif.memData  = mem_func(mif.memAddr);
                    mem_cnt      = 0;
                end else begin
                    mem_cnt++;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // Output monitor: every valid pulse is matched against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (mif.memRe) last_mem_addr = mif.memAddr;
            if (mif.cpuValid || mif.dispValid) begin
                chk("single_valid", {31'b0, mif.cpuValid & mif.dispValid}, 32'h0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", {31'b0, mif.dispValid}, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("grant_order", {31'b0, mif.dispValid}, {31'b0, e.disp});
                    chk("mem_addr", last_mem_addr, e.addr);
                    chk(e.disp ? "disp_data" : "cpu_data",
                        e.disp ? mif.dispData : mif.cpuData, e.data);
                end
            end
        end
    end

    // Single read: checks 1-cycle grant latency, memRe length and delivery.
    task automatic do_read(input bit disp, input logic [31:0] addr,
                           input logic [31:0] data, input int exp_re);
        int re_cycles = 0;
        bit done      = 1'b0;
        int i         = 0;
        sb_q.push_back('{disp, addr, data});
        @(negedge Clk);
        if (disp) begin
            mif.dispReq = 1'b1; mif.dispAddr = addr;
        end else begin
            mif.cpuReq = 1'b1;  mif.cpuAddr = addr;
        end
        @(negedge Clk);
        chk("grant_latency", {31'b0, mif.memRe}, 32'h1);
        while (!done && i < 200) begin
            if (mif.memRe) re_cycles++;
            if (disp ? mif.dispValid : mif.cpuValid) begin
                done = 1'b1;
                if (disp) mif.dispReq = 1'b0; else mif.cpuReq = 1'b0;
            end else begin
                @(negedge Clk);
                i++;
            end
        end
        chk("valid_seen", {31'b0, done}, 32'h1);
        chk("memre_cycles", re_cycles, exp_re);
    endtask

    initial begin
        int cpu_n;
        int disp_n;
        int i;
        logic [31:0] disp_hold;
        Rst = 1'b0;
        mif.cpuReq = 1'b0; mif.cpuAddr = 32'h0;
        mif.dispReq = 1'b0; mif.dispAddr = 32'h0;
        repeat (2) @(negedge Clk);
        chk("rst_memRe", {31'b0, mif.memRe}, 32'h0);
        chk("rst_memAddr", mif.memAddr, 32'h0);
        chk("rst_cpuData", mif.cpuData, 32'h0);
        chk("rst_dispData", mif.dispData, 32'h0);
        chk("rst_cpuValid", {31'b0, mif.cpuValid}, 32'h0);
        chk("rst_dispValid", {31'b0, mif.dispValid}, 32'h0);
        chk("rst_timeoutErr", {31'b0, mif.timeoutErr}, 32'h0);
        Rst = 1'b1;

        // Single CPU read, memory latency 2.
        mem_lat = 2;
        do_read(1'b0, 32'h10, 32'h3333_3333, 3);
        chk("cpu_hold", mif.cpuData, 32'h3333_3333);

        // Simultaneous requests: CPU first, then display.
        mem_lat = 1;
        sb_q.push_back('{1'b0, 32'h100, mem_func(32'h100)});
        sb_q.push_back('{1'b1, 32'h200, mem_func(32'h200)});
        @(negedge Clk);
        mif.cpuReq = 1'b1;  mif.cpuAddr = 32'h100;
        mif.dispReq = 1'b1; mif.dispAddr = 32'h200;
        cpu_n = 0; disp_n = 0; i = 0;
        while (i < 60) begin
            @(negedge Clk);
            if (mif.cpuValid)  begin cpu_n++;  mif.cpuReq = 1'b0;  end
            if (mif.dispValid) begin disp_n++; mif.dispReq = 1'b0; end
            i++;
        end
        chk("simul_cpu_pulses", cpu_n, 1);
        chk("simul_disp_pulses", disp_n, 1);

        // Starvation: 8 CPU grants, then display, then CPU again.
        for (int k = 0; k < 8; k++) sb_q.push_back('{1'b0, 32'h20, mem_func(32'h20)});
        sb_q.push_back('{1'b1, 32'h24, mem_func(32'h24)});
        sb_q.push_back('{1'b0, 32'h20, mem_func(32'h20)});
        @(negedge Clk);
        mif.cpuReq = 1'b1;  mif.cpuAddr = 32'h20;
        mif.dispReq = 1'b1; mif.dispAddr = 32'h24;
        cpu_n = 0; disp_n = 0; i = 0;
        while (!(cpu_n == 9 && disp_n == 1) && i < 400) begin
            @(negedge Clk);
            if (mif.dispValid) begin
                disp_n++;
                chk("starve_cpu_before_disp", cpu_n, 8);
                chk("starve_cnt_cleared", {28'b0, dut.u_starve.cnt_r}, 32'h0);
                mif.dispReq = 1'b0;
            end
            if (mif.cpuValid) begin
                cpu_n++;
                if (cpu_n == 9) mif.cpuReq = 1'b0;
            end
            i++;
        end
        chk("starve_done", {31'b0, (cpu_n == 9 && disp_n == 1)}, 32'h1);
        repeat (3) @(negedge Clk);
        chk("starve_sb_empty", sb_q.size(), 0);

        // memReady while idle must be ignored.
        disp_hold = mif.dispData;
        @(negedge Clk); #2 mem_force = 1'b1;
        @(negedge Clk); #2 mem_force = 1'b0;
        repeat (3) @(negedge Clk);
        chk("idle_ready_memRe", {31'b0, mif.memRe}, 32'h0);
        chk("idle_ready_dispData", mif.dispData, disp_hold);
        chk("idle_ready_cpuData", mif.cpuData, mem_func(32'h20));

        // Timeout: memory never answers.
        mem_en = 1'b0;
        do_read(1'b1, 32'h40, 32'hDEAD_BEEF, 15);
        chk("timeout_err_set", {31'b0, mif.timeoutErr}, 32'h1);
        chk("timeout_dispData", mif.dispData, 32'hDEAD_BEEF);
        mem_en = 1'b1;
        mem_lat = 1;
        do_read(1'b0, 32'h50, mem_func(32'h50), 2);
        chk("timeout_err_sticky", {31'b0, mif.timeoutErr}, 32'h1);

        // Reset in the middle of a CPU read.
        mem_lat = 10;
        @(negedge Clk);
        mif.cpuReq = 1'b1; mif.cpuAddr = 32'h80;
        repeat (3) @(negedge Clk);
        chk("midread_memRe_before", {31'b0, mif.memRe}, 32'h1);
        Rst = 1'b0;
        #1;
        chk("midread_memRe_async", {31'b0, mif.memRe}, 32'h0);
        chk("midread_timeoutErr", {31'b0, mif.timeoutErr}, 32'h0);
        mif.cpuReq = 1'b0;
        repeat (3) @(negedge Clk);
        chk("midread_no_valid", {31'b0, mif.cpuValid}, 32'h0);
        Rst = 1'b1;
        mem_lat = 2;
        do_read(1'b0, 32'h90, mem_func(32'h90), 3);

        repeat (3) @(negedge Clk);
        chk("final_sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/peek_arbiter.md
PEEK_ARBITER -- requirements
Module: peek_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: max consecutive CPU grants while a display request waits.
REQ-002 Parameter MEM_TIMEOUT, default 15: max wait cycles for memReady before a read is abandoned.
REQ-003 Clk  input  1  system clock; all state changes on the rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-low.
REQ-005 cpuReq  input  1  CPU read request; held until cpuValid.
REQ-006 cpuAddr  input  32  CPU read address; stable while cpuReq is high.
REQ-007 cpuData  output  32  read data returned to the CPU.
REQ-008 cpuValid  output  1  one-cycle pulse; cpuData is valid.
REQ-009 dispReq  input  1  display peek request; held until dispValid.
REQ-010 dispAddr  input  32  display peek address (memToPeek); stable while dispReq is high.
REQ-011 dispData  output  32  last completed peek data; holds between peeks (display refresh source).
REQ-012 dispValid  output  1  one-cycle pulse on peek completion.
REQ-013 memRe  output  1  memory read enable; held high until memReady or timeout.
REQ-014 memAddr  output  32  memory address; stable while memRe is high.
REQ-015 memData  input  32  memory read data; sampled when memReady is high.
REQ-016 memReady  input  1  memory read complete, single cycle.
REQ-017 timeoutErr  output  1  sticky flag; set on any timeout, cleared only by reset.

Function
REQ-018 FSM states: IDLE, CPU_RD, DISP_RD.
REQ-019 IDLE: if dispReq is high and starveCnt = STARVE_LIMIT, go to DISP_RD; else if cpuReq, go to CPU_RD; else if dispReq, go to DISP_RD; else stay.
REQ-020 Entering a read state registers memAddr from the winning requester's address and asserts memRe in the first cycle of that state; request-to-memRe latency is 1 cycle.
REQ-021 Read state with memReady high: register memData into cpuData or dispData, pulse the matching valid the next cycle, deassert memRe, return to IDLE.
REQ-022 No back-to-back grant in the completion cycle: at least one IDLE cycle separates two reads.
REQ-023 starveCnt (width clog2(STARVE_LIMIT+1)): increments on each CPU grant while dispReq is high, saturates at STARVE_LIMIT, clears on each DISP grant or when dispReq is low in IDLE.
REQ-024 Wait counter: counts cycles in a read state without memReady. On reaching MEM_TIMEOUT: deassert memRe, set timeoutErr, pulse the requester's valid with data 32'hDEADBEEF (dispData also updates), go to IDLE.
REQ-025 A requester dropping its request mid-read does not abort the read; the result is still delivered.
REQ-026 memReady while in IDLE is ignored.
REQ-027 cpuData holds its last value between reads; it is not cleared on completion.

Reset
REQ-028 Rst low: state forced to IDLE immediately (asynchronous), regardless of any in-flight read.
REQ-029 Reset values: memRe=0, memAddr=0, cpuData=0, dispData=0, cpuValid=0, dispValid=0, timeoutErr=0, starveCnt=0, wait counter=0.
REQ-030 An in-flight read is abandoned and no valid pulse is produced; first grant possible in the first cycle after Rst returns high.

Structure
REQ-031 The shared package holds the state encoding (IDLE=2'd0, CPU_RD=2'd1, DISP_RD=2'd2), the timeout data constant 32'hDEADBEEF, and the STARVE_LIMIT/MEM_TIMEOUT defaults.
REQ-032 The starvation counter is one sub-module, starve_counter (increment, clear, saturate, at-limit flag); everything else is in peek_arbiter.

Verification
REQ-033 Single CPU read: cpuReq, cpuAddr=32'h10; memory answers 32'h33333333 after 2 cycles -> memRe high for 3 cycles with memAddr=32'h10, then cpuValid pulses with cpuData=32'h33333333.
REQ-034 Simultaneous: cpuReq and dispReq both rise in the same cycle -> CPU served first, DISP second, each followed by exactly one valid pulse.
REQ-035 Starvation: cpuReq held continuously with dispReq high, memory latency 1 -> after 8 CPU grants the 9th grant goes to DISP; dispData=memData; starveCnt=0.
REQ-036 Timeout: dispReq with memReady never asserted -> memRe drops after 15 wait cycles, dispValid pulses with dispData=32'hDEADBEEF, timeoutErr=1 and stays set.
REQ-037 Reset mid-read: Rst low during CPU_RD -> memRe=0 at once, no cpuValid pulse; after Rst returns high, a new cpuReq is served normally.
